// File: rtl/ysyx_22050019_trap_ctrl.sv
// Trap sequencer: arbitrates ecall/mret/timer irq, drains the pipe,
// writes mepc/mcause/mstatus one per cycle, then redirects the IFU.
module ysyx_22050019_trap_ctrl #(
    parameter int XLEN      = 64,
    parameter int DRAIN_MAX = 16,
    parameter bit VEC_EN    = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ecall_req,
    input  logic [XLEN-1:0] ecall_pc,
    input  logic            mret_req,
    input  logic            irq_mtip,
    input  logic [XLEN-1:0] irq_pc,
    input  logic [XLEN-1:0] csr_mstatus,
    input  logic [XLEN-1:0] csr_mie,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    input  logic            pipe_idle,
    output logic            trap_ack,
    output logic            stall_o,
    output logic            csr_wen_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            flush_o,
    output logic            busy,
    output logic            drain_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_W_EPC,
        S_W_CAUSE,
        S_W_STATUS,
        S_REDIR
    } state_t;

    localparam logic [XLEN-1:0] ECALL_CAUSE = {{(XLEN-4){1'b0}}, 4'd11};
    localparam logic [XLEN-1:0] IRQ_CAUSE   = {1'b1, {(XLEN-4){1'b0}}, 3'd7};

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      cnt;
    logic            is_mret;
    logic            is_irq;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] rpc_q;
    logic            to_q;

    logic            irq_ok;
    logic            accept;
    logic            drain_to;
    logic            drain_exit;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] vec_pc;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] status_nxt;
    logic            unused_mie;

    assign unused_mie = ^{csr_mie[XLEN-1:8], csr_mie[6:0]};

    // reset gates acceptance so every output reads 0 while rst_n is low
    assign irq_ok     = irq_mtip & csr_mstatus[3] & csr_mie[7];
    assign accept     = rst_n & (state == S_IDLE)
                      & (ecall_req | mret_req | irq_ok);
    assign drain_to   = (cnt == 8'(DRAIN_MAX - 1));
    assign drain_exit = pipe_idle | drain_to;

    assign base   = {csr_mtvec[XLEN-1:2], 2'b00};
    assign vec_pc = base + {cause_q[XLEN-3:0], 2'b00};

    assign redirect_pc   = rpc_q;
    assign drain_timeout = to_q;

    // mstatus image for trap entry or mret
    always_comb begin
        status_nxt        = csr_mstatus;
        status_nxt[12:11] = 2'b11;
        if (is_mret) begin
            status_nxt[3] = csr_mstatus[7];
            status_nxt[7] = 1'b1;
        end else begin
            status_nxt[7] = csr_mstatus[3];
            status_nxt[3] = 1'b0;
        end
    end

    // redirect target selection
    always_comb begin
        tgt = base;
        if (is_mret) begin
            tgt = csr_mepc;
        end else if (VEC_EN && is_irq && csr_mtvec[1:0] == 2'b01) begin
            tgt = vec_pc;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // latched request, drain counter, sticky timeout, redirect target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            is_mret <= 1'b0;
            is_irq  <= 1'b0;
            pc_q    <= '0;
            cause_q <= '0;
            rpc_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            if (accept) begin
                is_mret <= ~ecall_req & mret_req;
                is_irq  <= ~ecall_req & ~mret_req;
                pc_q    <= ecall_req ? ecall_pc : irq_pc;
                cause_q <= ecall_req ? ECALL_CAUSE : IRQ_CAUSE;
                cnt     <= '0;
            end else if (state == S_DRAIN && !drain_exit) begin
                cnt <= cnt + 8'd1;
            end
            if (state == S_DRAIN && drain_to && !pipe_idle) begin
                to_q <= 1'b1;
            end
            if (state == S_W_STATUS) begin
                rpc_q <= tgt;
            end
        end
    end

    // next state and per-state outputs
    always_comb begin
        state_nxt      = state;
        trap_ack       = 1'b0;
        stall_o        = 1'b1;
        busy           = 1'b1;
        csr_wen_o      = 1'b0;
        csr_waddr_o    = '0;
        csr_wdata_o    = '0;
        redirect_valid = 1'b0;
        flush_o        = 1'b0;
        unique case (state)
            S_IDLE: begin
                stall_o  = 1'b0;
                busy     = 1'b0;
                trap_ack = accept;
                if (accept) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_exit) begin
                    state_nxt = is_mret ? S_W_STATUS : S_W_EPC;
                end
            end
            S_W_EPC: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = 12'h341;
                csr_wdata_o = pc_q;
                state_nxt   = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = 12'h342;
                csr_wdata_o = cause_q;
                state_nxt   = S_W_STATUS;
            end
            S_W_STATUS: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = 12'h300;
                csr_wdata_o = status_nxt;
                state_nxt   = S_REDIR;
            end
            S_REDIR: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    flush_o   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050019_trap_ctrl.sv
// Bench for the trap sequencer: directed plan cases plus random
// requests checked against a transaction-level model.
module tb_ysyx_22050019_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ecall_req, mret_req, irq_mtip, pipe_idle, redirect_ready;
    logic [63:0] ecall_pc, irq_pc, csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
    logic        trap_ack, stall_o, csr_wen_o, redirect_valid;
    logic        flush_o, busy, drain_timeout;
    logic [11:0] csr_waddr_o;
    logic [63:0] csr_wdata_o, redirect_pc;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_to = 1'b0;

    always #5 clk = ~clk;

    ysyx_22050019_trap_ctrl #(
        .XLEN(64), .DRAIN_MAX(16), .VEC_EN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ecall_req(ecall_req), .ecall_pc(ecall_pc),
        .mret_req(mret_req), .irq_mtip(irq_mtip), .irq_pc(irq_pc),
        .csr_mstatus(csr_mstatus), .csr_mie(csr_mie),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .pipe_idle(pipe_idle), .trap_ack(trap_ack), .stall_o(stall_o),
        .csr_wen_o(csr_wen_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
        .flush_o(flush_o), .busy(busy), .drain_timeout(drain_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // architectural mstatus after trap entry / mret
    function automatic logic [63:0] ms_after(input logic [63:0] ms,
                                             input bit ret);
        logic [63:0] r;
        r = (ms & ~64'h1888) | 64'h1800;
        if (ret) r = r | 64'h80 | (ms[7] ? 64'h8 : 64'h0);
        else     r = r | (ms[3] ? 64'h80 : 64'h0);
        return r;
    endfunction

    // d: cycles after accept until pipe_idle rises; rd: REDIR cycles before ready
    task automatic txn(input bit e, input bit m, input bit i,
                       input logic [63:0] epc, input logic [63:0] ipc,
                       input logic [63:0] ms, input logic [63:0] mtv,
                       input logic [63:0] mep, input logic [63:0] miev,
                       input int d, input int rd, input bit keep_irq);
        int kind, k, fw, rc, first_w, first_v;
        bit done, stable_ok, quiet_ok, hold_ok, upd;
        logic [63:0] tgt, pc0, new_ms;
        logic [63:0] ea[$], ed[$], wa[$], wd[$];
        kind = e ? 1 : m ? 2 : (i && ms[3] && miev[7]) ? 3 : 0;
        @(negedge clk);
        ecall_req = e; mret_req = m; irq_mtip = i;
        ecall_pc = epc; irq_pc = ipc; csr_mstatus = ms;
        csr_mtvec = mtv; csr_mepc = mep; csr_mie = miev;
        pipe_idle = (d == 0); redirect_ready = 1'b0;
        #1;
        chk("ack", trap_ack, kind != 0);
        chk("idle_busy", busy, 1'b0);
        if (kind == 0) begin
            @(negedge clk);
            ecall_req = 0; mret_req = 0; irq_mtip = 0;
            #1;
            chk("stay_idle", busy, 1'b0);
            return;
        end
        if (kind != 2) begin
            ea.push_back(64'h341); ed.push_back(kind == 3 ? ipc : epc);
            ea.push_back(64'h342);
            ed.push_back(kind == 3 ? 64'h8000_0000_0000_0007 : 64'd11);
        end
        new_ms = ms_after(ms, kind == 2);
        ea.push_back(64'h300); ed.push_back(new_ms);
        if (kind == 2) tgt = mep;
        else if (kind == 3 && mtv[1:0] == 2'b01) tgt = (mtv & ~64'h3) + 64'd28;
        else tgt = mtv & ~64'h3;
        k = (d > 16) ? 15 : (d > 0 ? d - 1 : 0);
        if (d > 16) exp_to = 1'b1;
        fw = 2 + k;
        rc = fw + ea.size();
        done = 0; stable_ok = 1; quiet_ok = 1; hold_ok = 1; upd = 0;
        first_w = -1; first_v = -1; pc0 = '0;
        for (int c = 1; c <= 80 && !done; c++) begin
            @(negedge clk);
            ecall_req = 0; mret_req = 0;
            if (!keep_irq) irq_mtip = 0;
            pipe_idle = (c >= d);
            redirect_ready = (c >= rc + rd);
            if (upd) begin csr_mstatus = new_ms; upd = 0; end
            #1;
            if (!stall_o || !busy) hold_ok = 0;
            if (csr_wen_o) begin
                if (first_w < 0) first_w = c;
                wa.push_back(64'(csr_waddr_o)); wd.push_back(csr_wdata_o);
                if (csr_waddr_o == 12'h300) upd = 1;
            end else if (csr_waddr_o != 0 || csr_wdata_o != 0) begin
                quiet_ok = 0;
            end
            if (redirect_valid) begin
                if (first_v < 0) begin first_v = c; pc0 = redirect_pc; end
                else if (redirect_pc !== pc0) stable_ok = 0;
            end
            if (flush_o) begin
                chk("flush_cycle", 64'(c), 64'(rc + rd));
                done = 1;
            end
        end
        chk("completed", done, 1'b1);
        chk("nwrites", 64'(wa.size()), 64'(ea.size()));
        for (int j = 0; j < ea.size() && j < wa.size(); j++) begin
            chk($sformatf("waddr%0d", j), wa[j], ea[j]);
            chk($sformatf("wdata%0d", j), wd[j], ed[j]);
        end
        chk("first_write", 64'(first_w), 64'(fw));
        chk("redir_cycle", 64'(first_v), 64'(rc));
        chk("redir_pc", pc0, tgt);
        chk("redir_stable", stable_ok, 1'b1);
        chk("quiet_bus", quiet_ok, 1'b1);
        chk("stall_busy", hold_ok, 1'b1);
        chk("timeout", drain_timeout, exp_to);
        @(negedge clk);
        if (!keep_irq) irq_mtip = 0;
        pipe_idle = 1; redirect_ready = 0;
        #1;
        chk("post_busy", busy, 1'b0);
        chk("post_stall", stall_o, 1'b0);
        chk("post_flush", flush_o, 1'b0);
        chk("post_ack", trap_ack, 1'b0);
    endtask

    initial begin
        bit seen, quiet;
        int r;
        rst_n = 0;
        ecall_req = 0; mret_req = 0; irq_mtip = 0;
        pipe_idle = 0; redirect_ready = 0;
        ecall_pc = '0; irq_pc = '0; csr_mstatus = '0;
        csr_mie = '0; csr_mtvec = '0; csr_mepc = '0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_wen", csr_wen_o, 1'b0);
        chk("rst_rv", redirect_valid, 1'b0);
        chk("rst_rpc", redirect_pc, 64'h0);
        chk("rst_to", drain_timeout, 1'b0);
        rst_n = 1;

        txn(1, 0, 0, 64'h8000_0010, 0, 64'h0A_0000_1808, 64'h8000_1000,
            0, 64'h80, 0, 0, 0);
        txn(0, 1, 0, 0, 0, 64'h80, 64'h8000_1000, 64'h8000_0014,
            64'h80, 0, 0, 0);
        txn(0, 0, 1, 0, 64'h8000_0200, 64'h8, 64'h8000_1001, 0,
            64'h80, 0, 0, 0);
        txn(0, 0, 1, 0, 64'h8000_0200, 64'h0, 64'h8000_1001, 0,
            64'h80, 0, 0, 0);
        txn(1, 0, 1, 64'h8000_0040, 64'h8000_0044, 64'h8, 64'h8000_1001,
            0, 64'h80, 2, 1, 1);
        txn(0, 0, 1, 0, 64'h8000_0044, 64'h8, 64'h8000_2000, 0,
            64'h80, 3, 0, 0);
        txn(1, 0, 0, 64'h8000_0100, 0, 64'h8, 64'h8000_3000, 0,
            64'h0, 200, 0, 0);
        txn(1, 0, 0, 64'h8000_0104, 0, 64'h0, 64'h8000_3000, 0,
            64'h0, 1, 5, 0);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 3);
            txn(r == 0 || r == 3, r == 1 || r == 3,
                r == 2 || (r == 0 && $urandom_range(0, 1) == 1),
                {32'h0, $urandom} & ~64'h3, {32'h0, $urandom} & ~64'h3,
                {$urandom, $urandom},
                {32'h0, $urandom},
                {32'h0, $urandom} & ~64'h3,
                $urandom_range(0, 1) == 1 ? 64'h80 : 64'h0,
                $urandom_range(0, 6), $urandom_range(0, 4), 0);
        end

        @(negedge clk);
        ecall_req = 1; ecall_pc = 64'h8000_0500; csr_mstatus = 64'h8;
        csr_mtvec = 64'h8000_1000; pipe_idle = 1; redirect_ready = 1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            ecall_req = 0;
            #1;
            if (csr_wen_o && csr_waddr_o == 12'h342) seen = 1;
        end
        chk("saw_wcause", seen, 1'b1);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_wen", csr_wen_o, 1'b0);
        chk("mid_rst_addr", 64'(csr_waddr_o), 64'h0);
        chk("mid_rst_data", csr_wdata_o, 64'h0);
        chk("mid_rst_stall", stall_o, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rv", redirect_valid, 1'b0);
        chk("mid_rst_rpc", redirect_pc, 64'h0);
        chk("mid_rst_to", drain_timeout, 1'b0);
        exp_to = 0;
        @(negedge clk);
        rst_n = 1;
        quiet = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (csr_wen_o || busy || redirect_valid || flush_o) quiet = 0;
        end
        chk("post_rst_quiet", quiet, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_trap_ctrl.md
Name: ysyx_22050019_trap_ctrl

Overview:
Trap sequencer that owns the CSR file's trap path. It accepts ecall, mret and machine-timer interrupt events, arbitrates between them, and stalls and drains the pipeline. It then performs the mepc/mcause/mstatus updates as a sequence of single-cycle CSR writes and issues a PC redirect to the IFU over a valid/ready handshake. It sits between EXU/WBU, the CLINT and the CSR file's write port.

Parameters:
XLEN, 64, data/PC width
DRAIN_MAX, 16, maximum cycles to wait for pipe_idle before proceeding anyway
VEC_EN, 1, 1 = honour mtvec.MODE==1 (vectored) for interrupts; 0 = always direct

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ecall_req  in  1  ecall retiring (level, held until trap_ack)
ecall_pc  in  XLEN  PC of the ecall
mret_req  in  1  mret retiring (level, held until trap_ack)
irq_mtip  in  1  CLINT timer pending (level)
irq_pc  in  XLEN  PC of the next instruction to commit (interrupt mepc)
csr_mstatus  in  XLEN  current mstatus
csr_mie  in  XLEN  current mie (bit 7 = MTIE used)
csr_mtvec  in  XLEN  current mtvec
csr_mepc  in  XLEN  current mepc
pipe_idle  in  1  IFU/LSU have no outstanding transactions
trap_ack  out  1  one-cycle pulse: request accepted
stall_o  out  1  hold pipeline fetch/issue
csr_wen_o  out  1  CSR write strobe
csr_waddr_o  out  12  CSR write address
csr_wdata_o  out  XLEN  CSR write data
redirect_valid  out  1  redirect PC valid
redirect_pc  out  XLEN  target PC
redirect_ready  in  1  IFU accepts redirect
flush_o  out  1  one-cycle pulse on the redirect handshake
busy  out  1  FSM not in IDLE
drain_timeout  out  1  sticky: a drain hit DRAIN_MAX

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; every output 0; internal latches 0. Reset mid-sequence aborts immediately and no further CSR write is issued.
- States: IDLE, DRAIN, W_EPC, W_CAUSE, W_STATUS, REDIR.
- Accept in IDLE, priority ecall > mret > interrupt.
  - Interrupt is eligible only when irq_mtip & csr_mstatus[3] & csr_mie[7].
  - On accept, trap_ack pulses for the same cycle. Kind is latched. For a trap, pc is latched (ecall_pc or irq_pc) together with cause: ecall = 11, interrupt = 64'h8000_0000_0000_0007.
  - Next state is DRAIN. A losing request is not acked and stays pending.
- stall_o=1 and busy=1 in every state except IDLE.
- DRAIN: an 8-bit counter counts cycles.
  - Exit on pipe_idle=1, or when the counter reaches DRAIN_MAX-1; the latter sets drain_timeout (cleared only by reset).
  - Exit goes to W_EPC for a trap, or W_STATUS for mret.
- W_EPC: csr_wen_o=1, addr 0x341, data = latched pc. Next is W_CAUSE.
- W_CAUSE: csr_wen_o=1, addr 0x342, data = latched cause. Next is W_STATUS.
- W_STATUS: csr_wen_o=1, addr 0x300. Data is csr_mstatus with these fields changed:
  - trap: MPIE[7] = MIE[3], MIE[3] = 0, MPP[12:11] = 2'b11.
  - mret: MIE[3] = MPIE[7], MPIE[7] = 1, MPP = 2'b11.
  - On leaving W_STATUS, redirect_pc is registered:
    - trap, direct mode: {csr_mtvec[63:2], 2'b00}.
    - interrupt with VEC_EN=1 and csr_mtvec[1:0]==2'b01: base + 4*cause[62:0].
    - mret: csr_mepc.
  - Next is REDIR.
- Exactly one CSR write per write state. csr_wen_o=0 elsewhere, and csr_waddr_o/csr_wdata_o are 0 then.
- REDIR: redirect_valid=1. redirect_pc stays stable until redirect_ready=1. On the handshake cycle flush_o=1, then the FSM goes to IDLE with stall_o=0 on the next cycle.
- No new request is accepted until IDLE. New accept is allowed the cycle after REDIR exits.
- Latency: ecall accepted at cycle T with pipe_idle=1 and redirect_ready=1 gives writes at T+2..T+4 and redirect at T+5.

Test Plan:
- ecall_req=1, ecall_pc=0x8000_0010, mtvec=0x8000_1000, mstatus=0x0A00001808, pipe_idle=1, ready=1 -> writes mepc=0x8000_0010, mcause=11, mstatus=0x0A00001880 (MPIE=1, MIE=0); redirect_pc=0x8000_1000 with flush pulse.
- mret_req with mstatus MPIE=1/MIE=0, mepc=0x8000_0014 -> single write to 0x300 with MIE=1, MPIE=1; redirect_pc=0x8000_0014; no mepc/mcause write.
- irq_mtip=1, MIE=1, MTIE=1, mtvec=0x8000_1001, irq_pc=0x8000_0200 -> mcause=0x8000_0000_0000_0007, mepc=0x8000_0200, redirect_pc=0x8000_101C. Repeat with MIE=0 -> no ack, stays IDLE.
- ecall and irq_mtip asserted in the same cycle -> ecall served first. Interrupt is accepted after return only if MIE=1 again.
- pipe_idle held 0 -> W_EPC entered exactly DRAIN_MAX cycles after entering DRAIN; drain_timeout=1 and remains set.
- redirect_ready held 0 for 5 cycles -> redirect_valid/pc stable and stall_o high throughout; rst_n pulsed low mid-W_CAUSE -> all outputs 0 immediately and no further writes.
